// File: rtl/mult_4x4_digit_seq.sv
// Digit-serial WIDTH x WIDTH unsigned multiplier sequencer feeding one external 4x4 multiplier.
// Walks all digit pairs (inner index j over b), shift-accumulating each 8-bit partial product.
module mult_4x4_digit_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [3:0]         mult_x,
    output logic [3:0]         mult_y,
    input  logic [7:0]         mult_p
);

    localparam int unsigned DIGITS = WIDTH / 4;
    localparam int unsigned DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIG_W-1:0] LastDigit = DIG_W'(DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [DIG_W-1:0]     i_q, j_q;
    logic                 in_ready_q, out_valid_q;
    logic [2*WIDTH-1:0]   out_p_q;
    logic [3:0]           mult_x_q, mult_y_q;

    logic [DIG_W-1:0]     i_d, j_d;
    logic                 last_pair;
    logic [2*WIDTH-1:0]   addend, acc_sum;

    always_comb begin
        last_pair = (i_q == LastDigit) && (j_q == LastDigit);
        addend    = (2 * WIDTH)'(mult_p) << (4 * (int'(i_q) + int'(j_q)));
        acc_sum   = acc_q + addend;
        i_d       = i_q;
        j_d       = j_q + DIG_W'(1);
        if (j_q == LastDigit) begin
            j_d = '0;
            i_d = last_pair ? '0 : i_q + DIG_W'(1);
        end
    end

    // Digit outputs are registered from the next indices so the DSP sees clean, glitch-free inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            mult_x_q    <= '0;
            mult_y_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q        <= in_a;
                        b_q        <= in_b;
                        acc_q      <= '0;
                        i_q        <= '0;
                        j_q        <= '0;
                        mult_x_q   <= in_a[3:0];
                        mult_y_q   <= in_b[3:0];
                        in_ready_q <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    acc_q <= acc_sum;
                    i_q   <= i_d;
                    j_q   <= j_d;
                    if (last_pair) begin
                        out_p_q     <= acc_sum;
                        out_valid_q <= 1'b1;
                        mult_x_q    <= '0;
                        mult_y_q    <= '0;
                        state_q     <= StDone;
                    end else begin
                        mult_x_q <= a_q[4*int'(i_d) +: 4];
                        mult_y_q <= b_q[4*int'(j_d) +: 4];
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign mult_x    = mult_x_q;
    assign mult_y    = mult_y_q;

endmodule
